// File: rtl/return_address_stack_pkg.sv
// -----------------------------------------------------------------------------
// return_address_stack_pkg
// Shared definitions for the return address stack:
//   - default WIDTH / DEPTH / STEP
//   - count-width expression (enough bits to hold the value DEPTH)
//   - occupancy FSM encoding (EMPTY / PARTIAL / FULL)
// -----------------------------------------------------------------------------
package return_address_stack_pkg;

    localparam int RAS_DEF_WIDTH = 64;
    localparam int RAS_DEF_DEPTH = 8;
    localparam int RAS_DEF_STEP  = 4;

    // count must be able to represent DEPTH itself, hence the extra bit
    function automatic int ras_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        RAS_EMPTY   = 2'b00,
        RAS_PARTIAL = 2'b01,
        RAS_FULL    = 2'b10
    } ras_state_e;

endpackage

// File: rtl/nbit_CLA_full_adder.sv
// -----------------------------------------------------------------------------
// nbit_CLA_full_adder
// WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups; group
// carries are resolved from group generate/propagate terms.
// Ports:
//   a, b  [WIDTH-1:0]  operands
//   cin               carry in
//   sum   [WIDTH-1:0]  a + b + cin (truncated)
//   cout              carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module nbit_CLA_full_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] a_pad;
    logic [PW-1:0] b_pad;
    logic [PW-1:0] sum_pad;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    // Pad bits are forced to propagate (a=1, b=0) so the final group carry
    // equals the carry out of the real top bit for any WIDTH.
    always_comb begin
        a_pad = '1;
        b_pad = '0;
        a_pad[WIDTH-1:0] = a;
        b_pad[WIDTH-1:0] = b;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = gi * 4;
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] c;

            assign g = a_pad[B+3:B] & b_pad[B+3:B];
            assign p = a_pad[B+3:B] ^ b_pad[B+3:B];

            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;

            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = grp_g[gi] | (grp_p[gi] & c[0]);

            assign sum_pad[B+3:B] = p ^ c[3:0];
        end
    endgenerate

    // Group carry chain: depends only on group G/P terms, never on sums.
    always_comb begin
        grp_c[0] = cin;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    assign sum  = sum_pad[WIDTH-1:0];
    assign cout = grp_c[NG];

endmodule

// File: rtl/ras_ret_addr.sv
// -----------------------------------------------------------------------------
// ras_ret_addr
// Forms the return address ra = push_pc + STEP (carry discarded) with the
// shared CLA adder.
// Ports:
//   push_pc [WIDTH-1:0]  PC of the call instruction
//   ra      [WIDTH-1:0]  return address
// -----------------------------------------------------------------------------
module ras_ret_addr #(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] push_pc,
    output logic [WIDTH-1:0] ra
);

    localparam logic [WIDTH-1:0] STEP_VEC = WIDTH'(STEP);

    logic carry_unused;

    nbit_CLA_full_adder #(
        .WIDTH(WIDTH)
    ) u_add (
        .a    (push_pc),
        .b    (STEP_VEC),
        .cin  (1'b0),
        .sum  (ra),
        .cout (carry_unused)
    );

endmodule

// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
// LIFO of return addresses for the fetch stage. A call pushes push_pc+STEP,
// a return pops; push+pop together replaces the top (tail call).
// Optional macro RAS_WRAP_EN: a push on a full stack overwrites the oldest
// entry (circular). Without it such a push is dropped. Either way overflow
// is set.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_pc       call request and PC of the call
//   pop                 return request
//   top_addr            top-of-stack address (0 when empty)
//   top_valid           stack non-empty
//   count               number of valid entries
//   full                count == DEPTH
//   overflow/underflow  sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int WIDTH = RAS_DEF_WIDTH,
    parameter int DEPTH = RAS_DEF_DEPTH,
    parameter int STEP  = RAS_DEF_STEP
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [WIDTH-1:0]                    push_pc,
    input  logic                                pop,
    output logic [WIDTH-1:0]                    top_addr,
    output logic                                top_valid,
    output logic [ras_count_width(DEPTH)-1:0]   count,
    output logic                                full,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int CW = ras_count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] entry_reg [DEPTH];
    logic [PW-1:0]    tp_reg;
    logic [CW-1:0]    count_reg;
    ras_state_e       state_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic [WIDTH-1:0] ra;
    logic [PW-1:0]    tp_inc;
    logic [PW-1:0]    tp_dec;

    ras_ret_addr #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_ret_addr (
        .push_pc(push_pc),
        .ra     (ra)
    );

    // Pointer arithmetic wraps naturally mod DEPTH (power of two)
    assign tp_inc = tp_reg + 1'b1;
    assign tp_dec = tp_reg - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            tp_reg        <= '0;
            count_reg     <= '0;
            state_reg     <= RAS_EMPTY;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (push && pop && (count_reg != '0)) begin
            // tail call: swap the top in place
            entry_reg[tp_reg] <= ra;
        end else if (push) begin
            // also covers push+pop on an empty stack (plain push)
            if (count_reg != DEPTH_C) begin
                tp_reg            <= tp_inc;
                entry_reg[tp_inc] <= ra;
                count_reg         <= count_reg + ONE_C;
                state_reg         <= (count_reg == DEPTH_C - ONE_C) ? RAS_FULL : RAS_PARTIAL;
            end else begin
                overflow_reg <= 1'b1;
`ifdef RAS_WRAP_EN
                // the slot after the top is the oldest entry when full
                tp_reg            <= tp_inc;
                entry_reg[tp_inc] <= ra;
`endif
            end
        end else if (pop) begin
            if (count_reg != '0) begin
                tp_reg    <= tp_dec;
                count_reg <= count_reg - ONE_C;
                state_reg <= (count_reg == ONE_C) ? RAS_EMPTY : RAS_PARTIAL;
            end else begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign top_addr  = (state_reg == RAS_EMPTY) ? '0 : entry_reg[tp_reg];
    assign top_valid = (state_reg != RAS_EMPTY);
    assign full      = (state_reg == RAS_FULL);
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_return_address_stack.sv
// -----------------------------------------------------------------------------
// tb_return_address_stack
// Directed stimulus against a queue-based model of the stack, compared on
// every falling edge, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_return_address_stack;

    localparam int W = 64;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [W-1:0]  push_pc;
    logic          pop;
    logic [W-1:0]  top_addr;
    logic          top_valid;
    logic [3:0]    count;
    logic          full;
    logic          overflow;
    logic          underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // model state
    logic [W-1:0] m_q[$];
    bit           m_ovf;
    bit           m_unf;

    return_address_stack #(
        .WIDTH(W),
        .DEPTH(D),
        .STEP (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_pc  (push_pc),
        .pop      (pop),
        .top_addr (top_addr),
        .top_valid(top_valid),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic model_apply(input logic ps, input logic pp, input logic [W-1:0] pc, input logic rs);
        logic [W-1:0] ra;
        ra = pc + 64'd4;
        if (rs) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (ps && pp && m_q.size() > 0) begin
            m_q[m_q.size()-1] = ra;
        end else if (ps) begin
            if (m_q.size() < D) begin
                m_q.push_back(ra);
            end else begin
                m_ovf = 1;
`ifdef RAS_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(ra);
`endif
            end
        end else if (pp) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_unf = 1;
        end
    endtask

    // one clock with the given inputs; returns just after the falling edge
    task automatic step(input logic ps, input logic pp, input logic [W-1:0] pc, input logic rs);
        push    = ps;
        pop     = pp;
        push_pc = pc;
        reset   = rs;
        @(posedge clk);
        model_apply(ps, pp, pc, rs);
        @(negedge clk);
        #1;
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_count", W'(count), W'(m_q.size()));
            chk("cyc_valid", W'(top_valid), W'(m_q.size() > 0));
            chk("cyc_top", top_addr, (m_q.size() > 0) ? m_q[m_q.size()-1] : '0);
            chk("cyc_full", W'(full), W'(m_q.size() == D));
            chk("cyc_ovf", W'(overflow), W'(m_ovf));
            chk("cyc_unf", W'(underflow), W'(m_unf));
        end
    end

    initial begin
        logic [W-1:0] base;
        push = 0; pop = 0; push_pc = '0; reset = 1;

        // reset then idle
        step(0, 0, '0, 1);
        chk_en = 1;
        repeat (3) step(0, 0, '0, 0);
        $display("idle after reset: count=%0d top=%h", count, top_addr);
        chk("rst_count", W'(count), 0);
        chk("rst_valid", W'(top_valid), 0);
        chk("rst_top", top_addr, 0);
        chk("rst_flags", W'({full, overflow, underflow}), 0);

        // basic push/push/pop
        step(1, 0, 64'h100, 0);
        $display("push 0x100: top=%h count=%0d", top_addr, count);
        chk("p1_top", top_addr, 64'h104);
        chk("p1_count", W'(count), 1);
        step(1, 0, 64'h200, 0);
        $display("push 0x200: top=%h count=%0d", top_addr, count);
        chk("p2_top", top_addr, 64'h204);
        chk("p2_count", W'(count), 2);
        step(0, 1, '0, 0);
        $display("pop: top=%h count=%0d", top_addr, count);
        chk("pop_top", top_addr, 64'h104);
        chk("pop_count", W'(count), 1);

        // underflow, then push+pop on empty
        step(0, 0, '0, 1);
        step(0, 1, '0, 0);
        $display("pop on empty: underflow=%0b", underflow);
        chk("unf_set", W'(underflow), 1);
        step(1, 1, 64'h40, 0);
        $display("push+pop empty 0x40: top=%h count=%0d", top_addr, count);
        chk("pp_empty_count", W'(count), 1);
        chk("pp_empty_top", top_addr, 64'h44);
        chk("unf_sticky", W'(underflow), 1);

        // fill past DEPTH
        step(0, 0, '0, 1);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, W'(i * 16), 0);
            $display("push %h: top=%h count=%0d full=%0b ovf=%0b", W'(i * 16), top_addr, count, full, overflow);
        end
`ifdef RAS_WRAP_EN
        base = 64'h84;
`else
        base = 64'h74;
`endif
        chk("fill_top", top_addr, base);
        chk("fill_ovf", W'(overflow), 1);
        chk("fill_full", W'(full), 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_top", top_addr, base - W'(i * 16));
            step(0, 1, '0, 0);
            $display("pop %0d: top=%h count=%0d", i, top_addr, count);
        end
        chk("drain_count", W'(count), 0);
        chk("drain_unf_clear", W'(underflow), 0);
        step(0, 1, '0, 0);
        $display("pop on drained: underflow=%0b", underflow);
        chk("drain_unf", W'(underflow), 1);

        // tail-call replace
        step(0, 0, '0, 1);
        step(1, 0, 64'h100, 0);
        step(1, 1, 64'h300, 0);
        $display("replace 0x300: top=%h count=%0d", top_addr, count);
        chk("repl_count", W'(count), 1);
        chk("repl_top", top_addr, 64'h304);

        // address wrap
        step(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        $display("push all-ones: top=%h", top_addr);
        chk("wrap_ra", top_addr, 64'h3);

        // reset beats a concurrent push
        step(0, 0, '0, 1);
        for (int i = 1; i <= 3; i++) step(1, 0, W'(i * 64'h1000), 0);
        step(1, 0, 64'h5000, 1);
        $display("reset with push: count=%0d top=%h", count, top_addr);
        chk("mrst_count", W'(count), 0);
        chk("mrst_top", top_addr, 0);
        chk("mrst_flags", W'({full, overflow, underflow, top_valid}), 0);
        step(0, 0, '0, 0);
        chk("mrst_hold", W'(count), 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
